mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACCESS_TIMEOUT, default 255, SHALL be the number of cycles without grant/response before an access is aborted.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Valid_In  input  1  SHALL mark the execute-stage outputs as valid this cycle.
REQ-005 Inst_In  input  32  SHALL carry the instruction; rd = Inst_In[11:7].
REQ-006 Inst_Type_In  input  5  SHALL carry the opcode class: 00100 imm, 01100 reg-reg, 00000 load, 01000 store, 11000 branch, 11111 MAC.
REQ-007 Result_In  input  32  SHALL carry the ALU result or effective address.
REQ-008 Operand_B_In  input  32  SHALL carry the store data.
REQ-009 Ready_Out  output  1  SHALL tell the execute stage that inputs are accepted this cycle; low means stall.
REQ-010 Dmem_Req_Out, Dmem_We_Out  output  1 each  SHALL be the memory request and write enable.
REQ-011 Dmem_Addr_Out, Dmem_Wdata_Out  output  32 each  SHALL be the word address and write data.
REQ-012 Dmem_Gnt_In, Dmem_Rvalid_In  input  1 each; Dmem_Rdata_In  input  32  SHALL be the grant, read-valid and read data.
REQ-013 Wb_Valid_Out  output  1; Wb_En_Out  output  1; Wb_Rd_Out  output  5; Wb_Data_Out  output  32; Inst_Type_Out  output  5  SHALL form the registered writeback bundle.
REQ-014 Mem_Err_Out  output  1  SHALL pulse for one cycle on a misaligned or timed-out access.

Function
REQ-015 FSM states SHALL be IDLE, REQ and WAIT_RD; Ready_Out SHALL be 1 only in IDLE.
REQ-016 In IDLE, Valid_In with an imm or reg-reg type SHALL produce, next cycle, a writeback with Wb_Valid=1, Wb_En=1, Wb_Data=Result_In and Wb_Rd=rd (latency 1).
REQ-017 In IDLE, Valid_In with a branch, MAC or unknown type SHALL produce, next cycle, Wb_Valid=1 and Wb_En=0.
REQ-018 In IDLE, a load or store SHALL latch address, data, rd and type, then enter REQ next cycle with Dmem_Req=1; Dmem_We SHALL be 1 for a store and 0 for a load.
REQ-019 In REQ, Dmem_Req, Dmem_We, Dmem_Addr and Dmem_Wdata SHALL be held stable until the cycle Dmem_Gnt_In=1 is sampled.
REQ-020 A store on grant SHALL return to IDLE with a writeback pulse (Wb_Valid=1, Wb_En=0) in the next cycle.
REQ-021 A load on grant SHALL deassert Dmem_Req and enter WAIT_RD; Dmem_Rvalid_In in REQ or IDLE SHALL be ignored.
REQ-022 In WAIT_RD, Dmem_Rvalid_In=1 SHALL register Wb_Data=Dmem_Rdata_In, Wb_En=1 and Wb_Valid=1, then return to IDLE.
REQ-023 Minimum load latency SHALL be 3 cycles from acceptance to Wb_Valid (grant and rvalid each on their first possible cycle); minimum store latency SHALL be 2 cycles.
REQ-024 Wb_En_Out SHALL be forced to 0 whenever rd = 0.
REQ-025 A load or store with Result_In[1:0] != 0 SHALL issue no request; next cycle it SHALL give Mem_Err=1 and Wb_Valid=1 with Wb_En=0, and the FSM SHALL stay in IDLE.
REQ-026 A timeout counter SHALL clear on entry to REQ or WAIT_RD and increment each cycle in those states.
REQ-027 When the timeout counter reaches ACCESS_TIMEOUT, the block SHALL drop Dmem_Req, pulse Mem_Err with Wb_Valid=1 and Wb_En=0, and return to IDLE.
REQ-028 The timeout counter SHALL saturate and never wrap.
REQ-029 Wb_Valid_Out and Mem_Err_Out SHALL be single-cycle pulses; Wb_Data, Wb_Rd and Inst_Type_Out SHALL hold their last values otherwise.
REQ-030 Inst_Type_Out SHALL equal the type of the instruction being written back.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force IDLE, clear the counter, and set every registered output to 0; Ready_Out SHALL then be 1.
REQ-032 Reset in the middle of REQ or WAIT_RD SHALL abandon the access with no writeback; a later Dmem_Rvalid_In SHALL be ignored.

Structure
REQ-033 Opcode-class constants, FSM state encoding and the ACCESS_TIMEOUT default SHALL live in a shared pipeline package used by the execute and memory stages.
REQ-034 The timeout counter SHALL be a single sub-module, mem_access_timer (clear, enable, expired).

Verification
REQ-035 Test: add-type (01100), Result_In=0x15, rd=5 -> one cycle later Wb_Valid=1, Wb_En=1, Wb_Data=0x15, Wb_Rd=5.
REQ-036 Test: load at address 0x40, grant on the first REQ cycle, rvalid one cycle later with data 0xDEADBEEF -> Wb_Data=0xDEADBEEF at 3 cycles; Ready_Out=0 for 2 cycles.
REQ-037 Test: store, address 0x80, data 0x1234, grant withheld for 4 cycles -> address, data and We=1 held stable through the stall; on grant, Wb_Valid=1 and Wb_En=0.
REQ-038 Test: load at address 0x42 -> no Dmem_Req; Mem_Err=1 and Wb_Valid=1 with Wb_En=0.
REQ-039 Test: ACCESS_TIMEOUT=8 with no grant -> Mem_Err pulse after the 8th REQ cycle, then IDLE and Ready_Out=1.
REQ-040 Test: rst_n pulsed low while in WAIT_RD, then rvalid -> no Wb_Valid, all outputs 0; load to rd=0 -> Wb_En=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared pipeline definitions used by the execute and memory stages:
//   - opcode-class encodings carried on Inst_Type
//   - memory-stage FSM state encoding
//   - default access timeout
//   - small opcode classification helpers
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  // Opcode classes
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_MAC    = 5'b11111;

  // Cycles spent waiting for grant / read data before an access is aborted
  localparam int unsigned ACCESS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2
  } mem_state_e;

  // Loads and stores go through the data-memory port
  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Only ALU-type results are written into the register file here
  function automatic logic writes_rd(input logic [4:0] op);
    return (op == OP_IMM) || (op == OP_REG);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
// Data-memory request/response bus between the memory stage (master) and the
// data memory / interconnect (slave).
//   Dmem_Req_Out    master->slave  request valid, held until grant
//   Dmem_We_Out     master->slave  1 = store, 0 = load
//   Dmem_Addr_Out   master->slave  32-bit word-aligned address
//   Dmem_Wdata_Out  master->slave  32-bit store data
//   Dmem_Gnt_In     slave->master  request accepted this cycle
//   Dmem_Rvalid_In  slave->master  read data valid this cycle
//   Dmem_Rdata_In   slave->master  32-bit read data
// -----------------------------------------------------------------------------
interface mem_stage_if;

  logic        Dmem_Req_Out;
  logic        Dmem_We_Out;
  logic [31:0] Dmem_Addr_Out;
  logic [31:0] Dmem_Wdata_Out;
  logic        Dmem_Gnt_In;
  logic        Dmem_Rvalid_In;
  logic [31:0] Dmem_Rdata_In;

  modport master (
    output Dmem_Req_Out, Dmem_We_Out, Dmem_Addr_Out, Dmem_Wdata_Out,
    input  Dmem_Gnt_In, Dmem_Rvalid_In, Dmem_Rdata_In
  );

  modport slave (
    input  Dmem_Req_Out, Dmem_We_Out, Dmem_Addr_Out, Dmem_Wdata_Out,
    output Dmem_Gnt_In, Dmem_Rvalid_In, Dmem_Rdata_In
  );

endinterface

// File: rtl/mem_access_timer.sv
// -----------------------------------------------------------------------------
// mem_access_timer
// Saturating cycle counter that bounds how long a memory access may wait.
//   clk        clock
//   rst_n      asynchronous active-low reset (count cleared)
//   clear_i    restart counting from zero (wins over enable_i)
//   enable_i   count this cycle
//   expired_o  high during the LIMIT-th counted cycle; the count reaches
//              LIMIT at the edge that ends it
// -----------------------------------------------------------------------------
module mem_access_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CW'(LIMIT))) begin
      // Saturate at LIMIT so a long stall can never wrap back to a small count
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Count holds the number of cycles already completed in the waiting state,
  // so LIMIT-1 means the current cycle is the last one allowed.
  assign expired_o = (count_q >= CW'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Pipeline memory stage. ALU-type results pass to writeback in one cycle;
// loads and stores are issued on the data-memory bus with a bounded wait.
//   clk, rst_n          clock, asynchronous active-low reset
//   Valid_In            execute-stage bundle valid
//   Inst_In             instruction (rd = [11:7])
//   Inst_Type_In        opcode class
//   Result_In           ALU result / effective address
//   Operand_B_In        store data
//   Ready_Out           stage can accept (IDLE only)
//   dmem                data-memory bus (master side)
//   Wb_Valid_Out        one-cycle writeback pulse
//   Wb_En_Out           register-file write enable (never for rd = 0)
//   Wb_Rd_Out           destination register
//   Wb_Data_Out         writeback data
//   Inst_Type_Out       opcode class of the written-back instruction
//   Mem_Err_Out         one-cycle pulse on misaligned or timed-out access
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ACCESS_TIMEOUT = ACCESS_TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Valid_In,
  input  logic [31:0]        Inst_In,
  input  logic [4:0]         Inst_Type_In,
  input  logic [31:0]        Result_In,
  input  logic [31:0]        Operand_B_In,
  output logic               Ready_Out,
  mem_stage_if.master        dmem,
  output logic               Wb_Valid_Out,
  output logic               Wb_En_Out,
  output logic [4:0]         Wb_Rd_Out,
  output logic [31:0]        Wb_Data_Out,
  output logic [4:0]         Inst_Type_Out,
  output logic               Mem_Err_Out
);

  mem_state_e  state_q, state_d;

  // Latched access
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  rd_q, type_q;
  logic        is_store_q;

  // Writeback bundle
  logic        wb_valid_q, wb_en_q, mem_err_q;
  logic [4:0]  wb_rd_q, inst_type_q;
  logic [31:0] wb_data_q;

  logic        timer_clear, timer_enable, timer_expired;

  logic [4:0]  rd_in;
  logic        misaligned;
  logic        start_access;
  logic        unused_inst_bits;

  assign rd_in            = Inst_In[11:7];
  assign unused_inst_bits = ^{Inst_In[31:12], Inst_In[6:0]};
  assign misaligned       = (Result_In[1:0] != 2'b00);
  assign start_access     = Valid_In && is_mem_op(Inst_Type_In) && !misaligned;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_access) state_d = ST_REQ;
      end
      ST_REQ: begin
        // A grant in the final allowed cycle still completes the access
        if (dmem.Dmem_Gnt_In)  state_d = is_store_q ? ST_IDLE : ST_WAIT_RD;
        else if (timer_expired) state_d = ST_IDLE;
      end
      ST_WAIT_RD: begin
        if (dmem.Dmem_Rvalid_In || timer_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Ready_Out         = 1'b0;
    dmem.Dmem_Req_Out = 1'b0;
    dmem.Dmem_We_Out  = 1'b0;
    timer_enable      = 1'b0;
    unique case (state_q)
      ST_IDLE: Ready_Out = 1'b1;
      ST_REQ: begin
        dmem.Dmem_Req_Out = 1'b1;
        dmem.Dmem_We_Out  = is_store_q;
        timer_enable      = 1'b1;
      end
      ST_WAIT_RD: timer_enable = 1'b1;
      default: ;
    endcase
    // Restart the wait budget on every entry into a waiting state
    timer_clear = (state_d != state_q) && (state_d != ST_IDLE);
  end

  assign dmem.Dmem_Addr_Out  = addr_q;
  assign dmem.Dmem_Wdata_Out = wdata_q;

  mem_access_timer #(
    .LIMIT (ACCESS_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (timer_expired)
  );

  // ---------------------------------------------------------------------------
  // Access latch and writeback bundle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      type_q      <= '0;
      is_store_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      inst_type_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      // Valid and error are pulses; the rest of the bundle holds
      wb_valid_q <= 1'b0;
      mem_err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (Valid_In) begin
            if (is_mem_op(Inst_Type_In)) begin
              if (misaligned) begin
                wb_valid_q  <= 1'b1;
                wb_en_q     <= 1'b0;
                mem_err_q   <= 1'b1;
                wb_rd_q     <= rd_in;
                inst_type_q <= Inst_Type_In;
              end else begin
                addr_q     <= Result_In;
                wdata_q    <= Operand_B_In;
                rd_q       <= rd_in;
                type_q     <= Inst_Type_In;
                is_store_q <= (Inst_Type_In == OP_STORE);
              end
            end else begin
              wb_valid_q  <= 1'b1;
              wb_en_q     <= writes_rd(Inst_Type_In) && (rd_in != 5'd0);
              wb_rd_q     <= rd_in;
              wb_data_q   <= Result_In;
              inst_type_q <= Inst_Type_In;
            end
          end
        end
        ST_REQ: begin
          if (dmem.Dmem_Gnt_In) begin
            if (is_store_q) begin
              wb_valid_q  <= 1'b1;
              wb_en_q     <= 1'b0;
              wb_rd_q     <= rd_q;
              inst_type_q <= type_q;
            end
          end else if (timer_expired) begin
            wb_valid_q  <= 1'b1;
            wb_en_q     <= 1'b0;
            mem_err_q   <= 1'b1;
            wb_rd_q     <= rd_q;
            inst_type_q <= type_q;
          end
        end
        ST_WAIT_RD: begin
          if (dmem.Dmem_Rvalid_In) begin
            wb_valid_q  <= 1'b1;
            wb_en_q     <= (rd_q != 5'd0);
            wb_rd_q     <= rd_q;
            wb_data_q   <= dmem.Dmem_Rdata_In;
            inst_type_q <= type_q;
          end else if (timer_expired) begin
            wb_valid_q  <= 1'b1;
            wb_en_q     <= 1'b0;
            mem_err_q   <= 1'b1;
            wb_rd_q     <= rd_q;
            inst_type_q <= type_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign Wb_Valid_Out  = wb_valid_q;
  assign Wb_En_Out     = wb_en_q;
  assign Wb_Rd_Out     = wb_rd_q;
  assign Wb_Data_Out   = wb_data_q;
  assign Inst_Type_Out = inst_type_q;
  assign Mem_Err_Out   = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed, self-checking bench for mem_stage (ACCESS_TIMEOUT = 8).
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        Valid_In;
  logic [31:0] Inst_In;
  logic [4:0]  Inst_Type_In;
  logic [31:0] Result_In;
  logic [31:0] Operand_B_In;
  logic        Ready_Out;
  logic        Wb_Valid_Out;
  logic        Wb_En_Out;
  logic [4:0]  Wb_Rd_Out;
  logic [31:0] Wb_Data_Out;
  logic [4:0]  Inst_Type_Out;
  logic        Mem_Err_Out;

  mem_stage_if dmem_if ();

  mem_stage #(
    .ACCESS_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Valid_In      (Valid_In),
    .Inst_In       (Inst_In),
    .Inst_Type_In  (Inst_Type_In),
    .Result_In     (Result_In),
    .Operand_B_In  (Operand_B_In),
    .Ready_Out     (Ready_Out),
    .dmem          (dmem_if.master),
    .Wb_Valid_Out  (Wb_Valid_Out),
    .Wb_En_Out     (Wb_En_Out),
    .Wb_Rd_Out     (Wb_Rd_Out),
    .Wb_Data_Out   (Wb_Data_Out),
    .Inst_Type_Out (Inst_Type_Out),
    .Mem_Err_Out   (Mem_Err_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  typ;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] opb;
    logic        exp_wb_valid;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [4:0]  exp_type;
    logic [31:0] exp_data;
    logic        chk_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] typ, input logic [4:0] rd,
                       input logic [31:0] result, input logic [31:0] opb);
    Valid_In     = 1'b1;
    Inst_Type_In = typ;
    Inst_In      = {20'h0, rd, 7'h13};
    Result_In    = result;
    Operand_B_In = opb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, OP_REG,    5'd5,  32'h0000_0015, 32'h0, 1'b1, 1'b1, 5'd5,  OP_REG,    32'h0000_0015, 1'b1, 1'b0};
    vecs[1] = '{1'b0, OP_LOAD,   5'd0,  32'h0000_0099, 32'h0, 1'b0, 1'b0, 5'd5,  OP_REG,    32'h0000_0015, 1'b1, 1'b0};
    vecs[2] = '{1'b1, OP_IMM,    5'd31, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 5'd31, OP_IMM,    32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{1'b1, OP_IMM,    5'd0,  32'h0000_0077, 32'h0, 1'b1, 1'b0, 5'd0,  OP_IMM,    32'h0000_0077, 1'b1, 1'b0};
    vecs[4] = '{1'b1, OP_BRANCH, 5'd3,  32'h0000_1000, 32'h0, 1'b1, 1'b0, 5'd3,  OP_BRANCH, 32'h0,         1'b0, 1'b0};
    vecs[5] = '{1'b1, OP_MAC,    5'd4,  32'h0000_2000, 32'h0, 1'b1, 1'b0, 5'd4,  OP_MAC,    32'h0,         1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'b10101,  5'd6,  32'h0000_3000, 32'h0, 1'b1, 1'b0, 5'd6,  5'b10101,  32'h0,         1'b0, 1'b0};
    vecs[7] = '{1'b1, OP_LOAD,   5'd7,  32'h0000_0042, 32'h0, 1'b1, 1'b0, 5'd7,  OP_LOAD,   32'h0,         1'b0, 1'b1};
    vecs[8] = '{1'b1, OP_STORE,  5'd0,  32'h0000_0081, 32'hABC, 1'b1, 1'b0, 5'd0, OP_STORE, 32'h0,         1'b0, 1'b1};
    vecs[9] = '{1'b1, OP_REG,    5'd10, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b1, 5'd10, OP_REG,    32'hA5A5_A5A5, 1'b1, 1'b0};

    rst_n        = 1'b0;
    Valid_In     = 1'b0;
    Inst_In      = '0;
    Inst_Type_In = '0;
    Result_In    = '0;
    Operand_B_In = '0;
    dmem_if.Dmem_Gnt_In    = 1'b0;
    dmem_if.Dmem_Rvalid_In = 1'b0;
    dmem_if.Dmem_Rdata_In  = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_ready",    Ready_Out, 1);
    check("rst_req",      dmem_if.Dmem_Req_Out, 0);
    check("rst_wb_valid", Wb_Valid_Out, 0);
    check("rst_wb_data",  Wb_Data_Out, 0);
    check("rst_err",      Mem_Err_Out, 0);
    $display("reset: ready=%b req=%b wb_valid=%b", Ready_Out, dmem_if.Dmem_Req_Out, Wb_Valid_Out);
    rst_n = 1'b1;
    tick();

    // ---------------- single-cycle vectors ----------------
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].valid) drive(vecs[i].typ, vecs[i].rd, vecs[i].result, vecs[i].opb);
      else begin
        Valid_In  = 1'b0;
        Result_In = vecs[i].result;
      end
      tick();
      check("vec_wb_valid", Wb_Valid_Out, vecs[i].exp_wb_valid);
      if (vecs[i].exp_wb_valid) check("vec_wb_en", Wb_En_Out, vecs[i].exp_en);
      check("vec_wb_rd",   Wb_Rd_Out, vecs[i].exp_rd);
      check("vec_type",    Inst_Type_Out, vecs[i].exp_type);
      if (vecs[i].chk_data) check("vec_wb_data", Wb_Data_Out, vecs[i].exp_data);
      check("vec_err",     Mem_Err_Out, vecs[i].exp_err);
      check("vec_req",     dmem_if.Dmem_Req_Out, 0);
      check("vec_ready",   Ready_Out, 1);
      $display("vec %0d: valid=%b type=%b rd=%0d res=0x%08h -> wb_valid=%b en=%b rd=%0d data=0x%08h err=%b",
               i, vecs[i].valid, vecs[i].typ, vecs[i].rd, vecs[i].result,
               Wb_Valid_Out, Wb_En_Out, Wb_Rd_Out, Wb_Data_Out, Mem_Err_Out);
    end
    Valid_In = 1'b0;
    tick();

    // ---------------- aligned load, minimum latency ----------------
    drive(OP_LOAD, 5'd9, 32'h40, 32'h0);
    tick();
    Valid_In = 1'b0;
    check("ld_ready_req",  Ready_Out, 0);
    check("ld_req",        dmem_if.Dmem_Req_Out, 1);
    check("ld_we",         dmem_if.Dmem_We_Out, 0);
    check("ld_addr",       dmem_if.Dmem_Addr_Out, 32'h40);
    check("ld_wbv_req",    Wb_Valid_Out, 0);
    dmem_if.Dmem_Gnt_In = 1'b1;
    tick();
    dmem_if.Dmem_Gnt_In = 1'b0;
    check("ld_ready_wait", Ready_Out, 0);
    check("ld_req_wait",   dmem_if.Dmem_Req_Out, 0);
    check("ld_wbv_wait",   Wb_Valid_Out, 0);
    dmem_if.Dmem_Rvalid_In = 1'b1;
    dmem_if.Dmem_Rdata_In  = 32'hDEAD_BEEF;
    tick();
    dmem_if.Dmem_Rvalid_In = 1'b0;
    check("ld_wb_valid",   Wb_Valid_Out, 1);
    check("ld_wb_en",      Wb_En_Out, 1);
    check("ld_wb_data",    Wb_Data_Out, 32'hDEAD_BEEF);
    check("ld_wb_rd",      Wb_Rd_Out, 9);
    check("ld_type",       Inst_Type_Out, OP_LOAD);
    check("ld_ready_done", Ready_Out, 1);
    $display("load 0x40: wb_valid=%b data=0x%08h rd=%0d", Wb_Valid_Out, Wb_Data_Out, Wb_Rd_Out);
    tick();
    check("ld_wbv_pulse",  Wb_Valid_Out, 0);
    check("ld_data_hold",  Wb_Data_Out, 32'hDEAD_BEEF);

    // ---------------- store with grant stall ----------------
    drive(OP_STORE, 5'd2, 32'h80, 32'h1234);
    tick();
    Valid_In = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("st_req_stall",   dmem_if.Dmem_Req_Out, 1);
      check("st_we_stall",    dmem_if.Dmem_We_Out, 1);
      check("st_addr_stall",  dmem_if.Dmem_Addr_Out, 32'h80);
      check("st_wdata_stall", dmem_if.Dmem_Wdata_Out, 32'h1234);
      check("st_ready_stall", Ready_Out, 0);
      check("st_wbv_stall",   Wb_Valid_Out, 0);
      tick();
    end
    check("st_req_gnt",  dmem_if.Dmem_Req_Out, 1);
    check("st_addr_gnt", dmem_if.Dmem_Addr_Out, 32'h80);
    dmem_if.Dmem_Gnt_In = 1'b1;
    tick();
    dmem_if.Dmem_Gnt_In = 1'b0;
    check("st_wb_valid", Wb_Valid_Out, 1);
    check("st_wb_en",    Wb_En_Out, 0);
    check("st_type",     Inst_Type_Out, OP_STORE);
    check("st_req_done", dmem_if.Dmem_Req_Out, 0);
    check("st_ready",    Ready_Out, 1);
    check("st_err",      Mem_Err_Out, 0);
    $display("store 0x80: wb_valid=%b en=%b ready=%b", Wb_Valid_Out, Wb_En_Out, Ready_Out);

    // ---------------- timeout with no grant (rvalid in REQ ignored) ----------------
    drive(OP_LOAD, 5'd1, 32'h100, 32'h0);
    dmem_if.Dmem_Rvalid_In = 1'b1;
    dmem_if.Dmem_Rdata_In  = 32'h1111_1111;
    tick();
    Valid_In = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("to_req",   dmem_if.Dmem_Req_Out, 1);
      check("to_err",   Mem_Err_Out, 0);
      check("to_wbv",   Wb_Valid_Out, 0);
      tick();
    end
    dmem_if.Dmem_Rvalid_In = 1'b0;
    check("to_err_pulse", Mem_Err_Out, 1);
    check("to_wb_valid",  Wb_Valid_Out, 1);
    check("to_wb_en",     Wb_En_Out, 0);
    check("to_req_drop",  dmem_if.Dmem_Req_Out, 0);
    check("to_ready",     Ready_Out, 1);
    check("to_wb_rd",     Wb_Rd_Out, 1);
    check("to_data_hold", Wb_Data_Out, 32'hDEAD_BEEF);
    $display("timeout: err=%b wb_valid=%b ready=%b", Mem_Err_Out, Wb_Valid_Out, Ready_Out);
    tick();
    check("to_err_clear", Mem_Err_Out, 0);
    check("to_wbv_clear", Wb_Valid_Out, 0);

    // ---------------- reset during WAIT_RD ----------------
    drive(OP_LOAD, 5'd12, 32'h40, 32'h0);
    tick();
    Valid_In = 1'b0;
    dmem_if.Dmem_Gnt_In = 1'b1;
    tick();
    dmem_if.Dmem_Gnt_In = 1'b0;
    check("rw_ready_wait", Ready_Out, 0);
    rst_n = 1'b0;
    #1;
    check("rw_ready",   Ready_Out, 1);
    check("rw_wbv",     Wb_Valid_Out, 0);
    check("rw_wb_data", Wb_Data_Out, 0);
    check("rw_wb_rd",   Wb_Rd_Out, 0);
    check("rw_type",    Inst_Type_Out, 0);
    check("rw_addr",    dmem_if.Dmem_Addr_Out, 0);
    tick();
    rst_n = 1'b1;
    dmem_if.Dmem_Rvalid_In = 1'b1;
    dmem_if.Dmem_Rdata_In  = 32'h5555_5555;
    tick();
    dmem_if.Dmem_Rvalid_In = 1'b0;
    check("rw_late_rvalid", Wb_Valid_Out, 0);
    check("rw_late_data",   Wb_Data_Out, 0);
    check("rw_late_ready",  Ready_Out, 1);
    $display("reset in WAIT_RD: wb_valid=%b data=0x%08h ready=%b", Wb_Valid_Out, Wb_Data_Out, Ready_Out);

    // ---------------- load to rd=0 ----------------
    drive(OP_LOAD, 5'd0, 32'h44, 32'h0);
    tick();
    Valid_In = 1'b0;
    dmem_if.Dmem_Gnt_In = 1'b1;
    tick();
    dmem_if.Dmem_Gnt_In = 1'b0;
    dmem_if.Dmem_Rvalid_In = 1'b1;
    dmem_if.Dmem_Rdata_In  = 32'hCAFE_F00D;
    tick();
    dmem_if.Dmem_Rvalid_In = 1'b0;
    check("r0_wb_valid", Wb_Valid_Out, 1);
    check("r0_wb_en",    Wb_En_Out, 0);
    check("r0_wb_data",  Wb_Data_Out, 32'hCAFE_F00D);
    check("r0_wb_rd",    Wb_Rd_Out, 0);
    $display("load rd0: wb_valid=%b en=%b data=0x%08h", Wb_Valid_Out, Wb_En_Out, Wb_Data_Out);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
